// File: rtl/pcm_pkg.sv
// pcm_pkg: constants and types shared across the PCM UART transmit slice.
//   DEF_CLKS_PER_BIT : default clock cycles per UART bit period
//   DEF_FIFO_DEPTH   : default sample buffer depth (power of two)
//   tx_state_t       : transmitter FSM state, 2-bit encoding
package pcm_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/pcm_sync_fifo.sv
// pcm_sync_fifo: single-clock FIFO with first-word fall-through read port.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset (clears pointers and level)
//   push  : write din; accepted when not full, or when full with a pop on the same edge
//   pop   : advance the read pointer; ignored when empty
//   din   : write data
//   dout  : head entry (valid while !empty)
//   level : current occupancy, 0..DEPTH
//   full  : level == DEPTH
//   empty : level == 0
module pcm_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign level   = count;
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcm_uart_tx.sv
// pcm_uart_tx: buffers decimated PCM samples and sends them as 8N1 UART frames.
//   CLK      : clock, rising edge
//   RST      : synchronous active-low reset; aborts any frame and flushes the buffer
//   IN       : 8-bit PCM sample
//   IN_VALID : one-cycle strobe, IN is a new sample
//   TX       : registered UART line, idle high
//   BUSY     : frame in progress or samples buffered
//   OVERFLOW : sticky, a sample was dropped on a full buffer
//   LEVEL    : buffer occupancy
module pcm_uart_tx
    import pcm_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    IN,
    input  logic                          IN_VALID,
    output logic                          TX,
    output logic                          BUSY,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic [7:0]  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        bit_end;
    logic        pop;

    assign bit_end = (baud == BAUD_LAST);
    // Pop either from IDLE or at the last cycle of STOP, which makes
    // back-to-back frames contiguous.
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign BUSY    = (state != IDLE) || (LEVEL != '0);

    pcm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (IN_VALID),
        .pop   (pop),
        .din   (IN),
        .dout  (head),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            TX       <= 1'b1;
            baud     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (IN_VALID && fifo_full && !pop) begin
                OVERFLOW <= 1'b1;
            end
            case (state)
                IDLE: begin
                    TX   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shreg <= head;
                        TX    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud   <= '0;
                        bitcnt <= '0;
                        TX     <= shreg[0];
                        state  <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bitcnt == 3'd7) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            shreg  <= {1'b0, shreg[7:1]};
                            TX     <= shreg[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (pop) begin
                            shreg <= head;
                            TX    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_uart_tx.sv
// tb_pcm_uart_tx: randomized and directed scoreboard bench for pcm_uart_tx.
// A timeline model predicts buffer occupancy, drops and frame start times;
// a UART receiver model decodes TX and checks each frame against the queue.
`timescale 1ns/1ps
module tb_pcm_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic [7:0]    IN;
    logic          TX;
    logic          BUSY;
    logic          OVERFLOW;
    logic [LW-1:0] LEVEL;

    pcm_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN       (IN),
        .IN_VALID (IN_VALID),
        .TX       (TX),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW),
        .LEVEL    (LEVEL)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Transmitter is free from edge free_edge on; a pop at edge p starts a
    // frame on cycle p+1 and the next pop may happen at edge p+FRAME.
    logic [7:0] mbuf[$];
    logic [7:0] exp_data[$];
    int         exp_start[$];
    int         free_edge  = 0;
    int         busy_until = -1;
    bit         m_ovf      = 1'b0;
    bit         started    = 1'b0;
    bit         last_rst   = 1'b0;

    always @(posedge CLK) begin : model
        bit do_pop;
        last_rst = RST;
        if (!RST) begin
            started = 1'b1;
            mbuf.delete();
            exp_data.delete();
            exp_start.delete();
            free_edge  = 0;
            busy_until = -1;
            m_ovf      = 1'b0;
        end else begin
            do_pop = (mbuf.size() != 0) && (cyc >= free_edge);
            if (do_pop) begin
                void'(mbuf.pop_front());
                exp_start.push_back(cyc + 1);
                free_edge  = cyc + FRAME;
                busy_until = cyc + FRAME;
            end
            if (IN_VALID) begin
                if (mbuf.size() < DEPTH) begin
                    mbuf.push_back(IN);
                    exp_data.push_back(IN);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        cyc++;
    end

    // ---------------- status checker ----------------
    int peak = 0;

    always @(negedge CLK) begin : status_chk
        bit busy_exp;
        if (started) begin
            busy_exp = (mbuf.size() != 0) || (cyc <= busy_until);
            chk("level", int'(LEVEL), mbuf.size());
            chk("overflow", int'(OVERFLOW), int'(m_ovf));
            chk("busy", int'(BUSY), int'(busy_exp));
            if (!busy_exp) chk("tx_idle_high", int'(TX), 1);
            if (int'(LEVEL) > peak) peak = int'(LEVEL);
        end
    end

    // ---------------- UART receiver monitor ----------------
    bit         rx_active = 1'b0;
    int         rx_t      = 0;
    logic [7:0] rx_byte   = '0;
    int         frames    = 0;

    always @(negedge CLK) begin : rx_mon
        if (started) begin
            if (!last_rst) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (TX == 1'b0) begin
                    rx_active = 1'b1;
                    rx_t      = 0;
                    frames++;
                    chk("start_queued", int'(exp_start.size() != 0), 1);
                    if (exp_start.size() != 0) chk("start_cycle", cyc, exp_start.pop_front());
                end
            end else begin
                rx_t++;
                if (rx_t == CPB / 2) begin
                    chk("start_bit", int'(TX), 0);
                end else if (rx_t > CPB && rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2) begin
                    rx_byte[rx_t / CPB - 1] = TX;
                end else if (rx_t == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", int'(TX), 1);
                    chk("data_queued", int'(exp_data.size() != 0), 1);
                    if (exp_data.size() != 0) chk("rx_data", int'(rx_byte), int'(exp_data.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] v);
        IN       = v;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST      = 1'b0;
        IN_VALID = 1'b0;
        tick();
        tick();
        RST  = 1'b1;
        peak = 0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (mbuf.size() == 0 && cyc > busy_until + 1 && !rx_active) done = 1'b1;
            else tick();
        end
        chk({name, "_drained"}, int'(done), 1);
        chk({name, "_all_received"}, exp_data.size(), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0;
        int f0;
        int acc;
        logic [127:0] bs;
        RST      = 1'b0;
        IN_VALID = 1'b0;
        IN       = '0;

        // Single sample 0xA5: start bit on cycle 2, BUSY drops at cycle 162.
        do_reset();
        chk("reset_tx", int'(TX), 1);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_level", int'(LEVEL), 0);
        t0 = cyc;
        send(8'hA5);
        chk("a5_tx_cycle1", int'(TX), 1);
        tick();
        chk("a5_tx_cycle2", int'(TX), 0);
        wait_until(t0 + 161);
        chk("a5_busy_cycle161", int'(BUSY), 1);
        tick();
        chk("a5_busy_cycle162", int'(BUSY), 0);
        drain("single");

        // Burst of three consecutive strobes.
        do_reset();
        f0 = frames;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        drain("burst");
        chk("burst_peak_level", peak, 2);
        chk("burst_frames", frames - f0, 3);

        // Ten strobes in one frame: one in flight, eight buffered, one dropped.
        do_reset();
        f0 = frames;
        for (int i = 0; i < 10; i++) send(8'(i));
        chk("ovf_set", int'(OVERFLOW), 1);
        drain("overflow");
        chk("ovf_sticky", int'(OVERFLOW), 1);
        chk("ovf_frames", frames - f0, 9);

        // Push into a full FIFO on the same edge as the STOP-end pop.
        do_reset();
        f0 = frames;
        t0 = cyc;
        for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
        chk("full_level", int'(LEVEL), 8);
        wait_until(t0 + 161);
        send(8'h55);
        chk("full_pushpop_level", int'(LEVEL), 8);
        chk("full_pushpop_ovf", int'(OVERFLOW), 0);
        drain("full_pushpop");
        chk("full_pushpop_frames", frames - f0, 10);

        // Reset pulse during data bit 4 with three samples queued.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
        wait_until(t0 + 90);
        RST      = 1'b0;
        IN       = 8'h77;
        IN_VALID = 1'b1;
        tick();
        RST      = 1'b1;
        IN_VALID = 1'b0;
        chk("midrst_tx", int'(TX), 1);
        chk("midrst_level", int'(LEVEL), 0);
        chk("midrst_ovf", int'(OVERFLOW), 0);
        chk("midrst_busy", int'(BUSY), 0);
        f0 = frames;
        repeat (400) tick();
        chk("midrst_no_frames", frames - f0, 0);

        // End-to-end: a simple ones-count decimator over a 128-bit bitstream.
        do_reset();
        f0 = frames;
        bs  = {$urandom, $urandom, $urandom, $urandom};
        acc = 0;
        for (int i = 0; i < 128; i++) begin
            acc += int'(bs[i]);
            if (i % 16 == 15) begin
                IN       = 8'(acc * 15);
                IN_VALID = 1'b1;
                acc      = 0;
            end else begin
                IN_VALID = 1'b0;
            end
            tick();
        end
        IN_VALID = 1'b0;
        drain("e2e");
        chk("e2e_frames", frames - f0, 8);

        // Random gaps and data, including occasional overflow.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 180)) tick();
            send(8'($urandom));
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
